chan_err_inj: RTL and testbench

- Channel stage between the K=7, rate-1/2 convolutional encoder and the Viterbi decoder in the tx/rx chain.
- Passes each 2-bit encoded symbol through with one cycle of latency.
- Flips one bit of a symbol when a 16-bit LFSR hits a threshold, with a guaranteed minimum gap between injections so the decoder can still correct every error.
- Exposes the injection mask, a symbol counter and an injected-error counter for bench scoreboarding.

---
 rtl/viterbi_pkg.sv | 22 ++
 rtl/lfsr16.sv | 27 ++
 rtl/chan_err_inj.sv | 129 ++++++++++++
 tb/tb_chan_err_inj.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the convolutional-code tx/rx chain.
// No logic; the LFSR step helper is purely combinational.
// Not applicable: no flow control here.
package viterbi_pkg;

    // One rate-1/2 encoded symbol, {g1, g0}
    typedef logic [1:0] sym_t;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        ARMED    = 1'b0,
        COOLDOWN = 1'b1
    } inj_state_t;

    // One right-shift step of the Galois LFSR
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps once per cycle with adv high.
// q is the registered state; the new value appears one cycle after adv.
// No backpressure: adv low simply holds the state.
module lfsr16
    import viterbi_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] q
);

    // An all-zero state would lock the LFSR, so a zero seed becomes 1
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // State register: reload seed on reset, step on adv
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= SEED_NZ;
        end else if (adv) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/chan_err_inj.sv
// Channel stage: passes encoded symbols through, flipping one bit on LFSR hits.
// Latency: exactly one cycle from valid_i/sym_i to valid_o/sym_o.
// No backpressure: every valid_i cycle is accepted; bubbles freeze all state.
module chan_err_inj
    import viterbi_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [8:0]  THRESH    = 9'd16,
    parameter int unsigned GAP       = 35,
    parameter int unsigned WCW       = 16,
    parameter int unsigned ECW       = 16
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_i,
    input  sym_t           sym_i,
    input  logic           inj_en_i,
    output logic           valid_o,
    output sym_t           sym_o,
    output sym_t           err_inj_o,
    output logic [WCW-1:0] word_ct_o,
    output logic [ECW-1:0] error_counter_o
);

    localparam int unsigned    GW     = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0]  GAP_LD = GW'(GAP);

    logic [15:0]   lfsr;
    logic          hit;
    logic          inj;
    sym_t          mask;
    inj_state_t    state;
    inj_state_t    state_nxt;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_nxt;
    logic          unused_lfsr_hi;

    // The LFSR steps only on accepted symbols; decisions use the pre-step value
    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (valid_i),
        .q   (lfsr)
    );

    // Only the threshold byte and the bit-select are consumed
    assign unused_lfsr_hi = ^lfsr[15:9];

    // 9-bit compare so THRESH=256 means "always" and 0 means "never"
    assign hit = valid_i && inj_en_i && ({1'b0, lfsr[7:0]} < THRESH);

    // FSM state and cooldown counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ARMED;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Next state: arm a cooldown after an injection, drain it on valid symbols
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        case (state)
            ARMED: begin
                if (hit && (GAP != 0)) begin
                    state_nxt = COOLDOWN;
                    gap_nxt   = GAP_LD;
                end
            end
            COOLDOWN: begin
                if (valid_i) begin
                    gap_nxt = gap_cnt - GW'(1);
                    if (gap_cnt == GW'(1)) begin
                        state_nxt = ARMED;
                    end
                end
            end
        endcase
    end

    // Output decode: a single-bit mask, chosen by lfsr[8], only when armed
    always_comb begin
        mask = 2'b00;
        if ((state == ARMED) && hit) begin
            mask = lfsr[8] ? 2'b10 : 2'b01;
        end
    end

    assign inj = |mask;

    // Registered datapath: sym_o holds across bubbles, mask clears
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_o   <= 1'b0;
            sym_o     <= 2'b00;
            err_inj_o <= 2'b00;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                sym_o     <= sym_i ^ mask;
                err_inj_o <= mask;
            end else begin
                err_inj_o <= 2'b00;
            end
        end
    end

    // Saturating symbol and injection counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_ct_o       <= '0;
            error_counter_o <= '0;
        end else begin
            if (valid_i && (word_ct_o != '1)) begin
                word_ct_o <= word_ct_o + WCW'(1);
            end
            if (inj && (error_counter_o != '1)) begin
                error_counter_o <= error_counter_o + ECW'(1);
            end
        end
    end

endmodule

// File: tb/tb_chan_err_inj.sv
// Directed and model-based checks of chan_err_inj across several parameter sets.
// Each instance is exercised in its own phase; idle instances see valid_i=0.
// Expected masks come from hand-stepped LFSR values starting at 16'hACE1.
module tb_chan_err_inj;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus and observation
    // 0: passthrough  1: gap 3  2: gap 2 bubbles  3: gap 0 enable  4: saturation  5: golden
    logic        r  [6];
    logic        v  [6];
    logic        e  [6];
    logic [1:0]  s  [6];
    logic        vo [6];
    logic [1:0]  so [6];
    logic [1:0]  mo [6];
    logic [15:0] wc [6];
    logic [15:0] ec [6];
    logic [1:0]  ec_sat;

    int n_tests = 0;
    int n_fail  = 0;

    chan_err_inj #(.THRESH(9'd0)) u_pass (
        .clk(clk), .rst(r[0]), .valid_i(v[0]), .sym_i(s[0]), .inj_en_i(e[0]),
        .valid_o(vo[0]), .sym_o(so[0]), .err_inj_o(mo[0]),
        .word_ct_o(wc[0]), .error_counter_o(ec[0]));

    chan_err_inj #(.THRESH(9'd256), .GAP(3)) u_g3 (
        .clk(clk), .rst(r[1]), .valid_i(v[1]), .sym_i(s[1]), .inj_en_i(e[1]),
        .valid_o(vo[1]), .sym_o(so[1]), .err_inj_o(mo[1]),
        .word_ct_o(wc[1]), .error_counter_o(ec[1]));

    chan_err_inj #(.THRESH(9'd256), .GAP(2)) u_g2 (
        .clk(clk), .rst(r[2]), .valid_i(v[2]), .sym_i(s[2]), .inj_en_i(e[2]),
        .valid_o(vo[2]), .sym_o(so[2]), .err_inj_o(mo[2]),
        .word_ct_o(wc[2]), .error_counter_o(ec[2]));

    chan_err_inj #(.THRESH(9'd256), .GAP(0)) u_g0 (
        .clk(clk), .rst(r[3]), .valid_i(v[3]), .sym_i(s[3]), .inj_en_i(e[3]),
        .valid_o(vo[3]), .sym_o(so[3]), .err_inj_o(mo[3]),
        .word_ct_o(wc[3]), .error_counter_o(ec[3]));

    chan_err_inj #(.THRESH(9'd256), .GAP(0), .ECW(2)) u_sat (
        .clk(clk), .rst(r[4]), .valid_i(v[4]), .sym_i(s[4]), .inj_en_i(e[4]),
        .valid_o(vo[4]), .sym_o(so[4]), .err_inj_o(mo[4]),
        .word_ct_o(wc[4]), .error_counter_o(ec_sat));

    assign ec[4] = {14'd0, ec_sat};

    chan_err_inj u_def (
        .clk(clk), .rst(r[5]), .valid_i(v[5]), .sym_i(s[5]), .inj_en_i(e[5]),
        .valid_o(vo[5]), .sym_o(so[5]), .err_inj_o(mo[5]),
        .word_ct_o(wc[5]), .error_counter_o(ec[5]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present one input cycle to instance k, then sample 1 time unit after the edge
    task automatic send(input int k, input logic vld, input logic [1:0] sym, input logic en);
        v[k] = vld;
        s[k] = sym;
        e[k] = en;
        @(posedge clk);
        #1;
        v[k] = 1'b0;
    endtask

    // Reference LFSR step for the golden model
    function automatic logic [15:0] m_next(input logic [15:0] q);
        logic [15:0] n;
        n = {1'b0, q[15:1]};
        if (q[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Hand-stepped lfsr[8] values: s0..s14 = 0,0,1,0,0,0,1,1,0,1,0,0,0,1,1
    logic       bv  [8] = '{1, 0, 0, 1, 1, 1, 0, 1};
    logic [1:0] bs  [8] = '{2'd3, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3};
    logic [1:0] bm  [8] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    logic [1:0] bso [8] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd3};
    logic [1:0] enm [5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [1:0] stm [6] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
    logic [1:0] ste [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    initial begin
        logic [1:0]  sym;
        logic [1:0]  m;
        logic [15:0] ml;
        logic        mcool;
        logic        vld;
        logic        en;
        int          mgap;
        int          mec;
        int          mwc;
        int          dprev;

        for (int k = 0; k < 6; k++) begin
            r[k] = 1'b0;
            v[k] = 1'b0;
            s[k] = 2'b00;
            e[k] = 1'b1;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rst_vo%0d", k), 32'(vo[k]), 32'd0);
            chk($sformatf("rst_so%0d", k), 32'(so[k]), 32'd0);
            chk($sformatf("rst_mo%0d", k), 32'(mo[k]), 32'd0);
            chk($sformatf("rst_wc%0d", k), 32'(wc[k]), 32'd0);
            chk($sformatf("rst_ec%0d", k), 32'(ec[k]), 32'd0);
        end
        for (int k = 0; k < 6; k++) r[k] = 1'b1;

        // Passthrough with THRESH=0
        for (int i = 0; i < 100; i++) begin
            sym = 2'($urandom_range(0, 3));
            send(0, 1'b1, sym, 1'b1);
            chk("pass_vo", 32'(vo[0]), 32'd1);
            chk("pass_so", 32'(so[0]), 32'(sym));
            chk("pass_mo", 32'(mo[0]), 32'd0);
        end
        chk("pass_wc", 32'(wc[0]), 32'd100);
        chk("pass_ec", 32'(ec[0]), 32'd0);

        // Gap timing, GAP=3: injections on symbols 0, 4, 8 (lfsr[8]=0 each time)
        for (int i = 0; i < 12; i++) begin
            sym = 2'(i);
            m   = ((i % 4) == 0) ? 2'b01 : 2'b00;
            send(1, 1'b1, sym, 1'b1);
            chk($sformatf("gap_mo%0d", i), 32'(mo[1]), 32'(m));
            chk($sformatf("gap_so%0d", i), 32'(so[1]), 32'(sym ^ m));
        end
        chk("gap_ec", 32'(ec[1]), 32'd3);
        chk("gap_wc", 32'(wc[1]), 32'd12);

        // Bubbles, GAP=2
        for (int i = 0; i < 8; i++) begin
            send(2, bv[i], bs[i], 1'b1);
            chk($sformatf("bub_vo%0d", i), 32'(vo[2]), 32'(bv[i]));
            chk($sformatf("bub_mo%0d", i), 32'(mo[2]), 32'(bm[i]));
            chk($sformatf("bub_so%0d", i), 32'(so[2]), 32'(bso[i]));
        end
        chk("bub_ec", 32'(ec[2]), 32'd2);
        chk("bub_wc", 32'(wc[2]), 32'd5);

        // Enable gating, GAP=0: 10 suppressed, then 5 injections at lfsr s10..s14
        for (int i = 0; i < 10; i++) begin
            send(3, 1'b1, 2'(i), 1'b0);
            chk($sformatf("en_off_mo%0d", i), 32'(mo[3]), 32'd0);
        end
        chk("en_off_ec", 32'(ec[3]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            send(3, 1'b1, 2'b00, 1'b1);
            chk($sformatf("en_on_mo%0d", i), 32'(mo[3]), 32'(enm[i]));
            chk($sformatf("en_on_so%0d", i), 32'(so[3]), 32'(enm[i]));
        end
        chk("en_on_ec", 32'(ec[3]), 32'd5);
        chk("en_wc", 32'(wc[3]), 32'd15);

        // Saturation with a 2-bit error counter
        for (int i = 0; i < 6; i++) begin
            send(4, 1'b1, 2'b11, 1'b1);
            chk($sformatf("sat_mo%0d", i), 32'(mo[4]), 32'(stm[i]));
            chk($sformatf("sat_ec%0d", i), 32'(ec[4]), 32'(ste[i]));
            chk($sformatf("sat_wc%0d", i), 32'(wc[4]), 32'(i + 1));
        end

        // Mid-run reset on the GAP=3 instance: inject at s12, then reset in cooldown
        send(1, 1'b1, 2'b00, 1'b1);
        chk("mr_pre_mo", 32'(mo[1]), 32'd1);
        send(1, 1'b1, 2'b00, 1'b1);
        chk("mr_cool_mo", 32'(mo[1]), 32'd0);
        r[1] = 1'b0;
        v[1] = 1'b1;
        s[1] = 2'b11;
        @(posedge clk);
        #1;
        r[1] = 1'b1;
        v[1] = 1'b0;
        chk("mr_vo", 32'(vo[1]), 32'd0);
        chk("mr_so", 32'(so[1]), 32'd0);
        chk("mr_mo", 32'(mo[1]), 32'd0);
        chk("mr_wc", 32'(wc[1]), 32'd0);
        chk("mr_ec", 32'(ec[1]), 32'd0);
        // Armed again and seeded: lfsr[8] of the seed is 0, so mask 01 (s14 would give 10)
        send(1, 1'b1, 2'b11, 1'b1);
        chk("mr_post_mo", 32'(mo[1]), 32'd1);
        chk("mr_post_so", 32'(so[1]), 32'd2);
        chk("mr_post_ec", 32'(ec[1]), 32'd1);
        chk("mr_post_wc", 32'(wc[1]), 32'd1);
        send(1, 1'b1, 2'b11, 1'b1);
        chk("mr_post_cool", 32'(mo[1]), 32'd0);

        // Golden model, default parameters, random bubbles and enable
        ml    = 16'hACE1;
        mcool = 1'b0;
        mgap  = 0;
        mec   = 0;
        mwc   = 0;
        dprev = -1;
        while (mwc < 2048) begin
            vld = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 15) != 0);
            sym = 2'($urandom_range(0, 3));
            m   = 2'b00;
            if (vld) begin
                if (!mcool) begin
                    if (en && (ml[7:0] < 8'd16)) begin
                        m     = ml[8] ? 2'b10 : 2'b01;
                        mcool = 1'b1;
                        mgap  = 35;
                        mec++;
                    end
                end else begin
                    mgap--;
                    if (mgap == 0) mcool = 1'b0;
                end
                ml = m_next(ml);
            end
            send(5, vld, sym, en);
            chk("gold_vo", 32'(vo[5]), 32'(vld));
            chk("gold_mo", 32'(mo[5]), 32'(m));
            if (vld) begin
                chk("gold_so", 32'(so[5]), 32'(sym ^ m));
                if (mo[5] != 2'b00) begin
                    if (dprev >= 0) chk("gold_spacing", 32'((mwc - dprev) >= 36), 32'd1);
                    dprev = mwc;
                end
                mwc++;
            end
        end
        chk("gold_ec", 32'(ec[5]), 32'(mec));
        chk("gold_wc", 32'(wc[5]), 32'(mwc));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
